// File: rtl/led_shift_driver.sv
// Serialises a WIDTH-bit LED word into a 74HC595-style chain (sdata/sclk/latch).
// A frame goes out after reset, when the word differs from the last one sent, or on refresh.
module led_shift_driver #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] leds,
    input  logic             refresh,
    output logic             sdata,
    output logic             sclk,
    output logic             latch,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = $clog2(2 * CLK_DIV);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_END  = DW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] last_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [DW-1:0]    div_cnt_q;
    logic             dirty_q;
    logic             pend_q;
    logic             sdata_q;
    logic             sclk_q;
    logic             latch_q;
    logic             busy_q;
    logic             done_q;
    logic             start_d;

    assign start_d = (leds != last_q) | dirty_q | pend_q | refresh;

    assign sdata = sdata_q;
    assign sclk  = sclk_q;
    assign latch = latch_q;
    assign busy  = busy_q;
    assign done  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // dirty forces a full frame after reset, so an aborted frame is always resent
            state_q   <= IDLE;
            shadow_q  <= '0;
            last_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            dirty_q   <= 1'b1;
            pend_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sclk_q    <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        shadow_q  <= leds;
                        bit_cnt_q <= BIT_LAST;
                        div_cnt_q <= '0;
                        sdata_q   <= leds[WIDTH-1];
                        sclk_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        dirty_q   <= 1'b0;
                        pend_q    <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (refresh) pend_q <= 1'b1;
                    if (div_cnt_q == DIV_END) begin
                        div_cnt_q <= '0;
                        sclk_q    <= 1'b0;
                        if (bit_cnt_q != '0) begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                            sdata_q   <= shadow_q[bit_cnt_q - 1'b1];
                        end else begin
                            latch_q <= 1'b1;
                            state_q <= LATCH;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                        if (div_cnt_q == DIV_HALF) sclk_q <= 1'b1;
                    end
                end
                LATCH: begin
                    // div_cnt was cleared on the last shift edge and times the strobe here
                    if (refresh) pend_q <= 1'b1;
                    if (div_cnt_q == DIV_HALF) begin
                        div_cnt_q <= '0;
                        latch_q   <= 1'b0;
                        sdata_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        last_q    <= shadow_q;
                        state_q   <= IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: frame-level reference model plus a serial-bus monitor
// that rebuilds each latched word from sclk rising edges.
module tb_led_shift_driver;

    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = WIDTH * 2 * CLK_DIV + CLK_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             refresh = 1'b0;
    logic [WIDTH-1:0] leds = '0;
    logic             sdata, sclk, latch, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_shift_driver #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .leds(leds), .refresh(refresh),
        .sdata(sdata), .sclk(sclk), .latch(latch), .busy(busy), .done(done)
    );

    // Frame-level model: a frame is just a countdown of FRAME cycles carrying a snapshot.
    int               m_rem = 0;
    int               m_frames = 0;
    logic [WIDTH-1:0] m_last = '0;
    logic [WIDTH-1:0] m_snap = '0;
    bit               m_dirty = 1'b1, m_pend = 1'b0, m_busy = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_last = '0; m_snap = '0;
            m_dirty = 1'b1; m_pend = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                if (refresh) m_pend = 1'b1;
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_last = m_snap; m_frames++;
                end
            end else if (leds != m_last || m_dirty || m_pend || refresh) begin
                m_snap = leds; m_rem = FRAME; m_busy = 1'b1;
                m_dirty = 1'b0; m_pend = 1'b0;
            end
        end
    end

    // Bus monitor, sampled on the falling edge.
    logic             p_sclk = 1'b0, p_latch = 1'b0, p_busy = 1'b0, p_sdata = 1'b0;
    logic [WIDTH-1:0] shreg = '0;
    logic [WIDTH-1:0] cap_q[$];
    int nbits = 0, hi_run = 0, lt_run = 0, bz_run = 0;
    int busy_len = 0, latch_len = 0, n_latch = 0, n_sclk = 0, n_busy_rise = 0;

    always @(negedge clk) begin
        checks++;
        if (busy !== m_busy) begin
            failures++; $display("FAIL busy_vs_model t=%0t got=%b exp=%b", $time, busy, m_busy);
        end
        checks++;
        if (done !== m_done) begin
            failures++; $display("FAIL done_vs_model t=%0t got=%b exp=%b", $time, done, m_done);
        end
        if (!m_busy) begin
            checks++;
            if ({sdata, sclk, latch} !== 3'b000) begin
                failures++; $display("FAIL idle_outputs t=%0t got=%b exp=000", $time, {sdata, sclk, latch});
            end
        end
        if (busy === 1'b1 && p_busy === 1'b0) begin
            n_busy_rise++; nbits = 0;
        end
        if (sclk === 1'b1 && p_sclk === 1'b0) begin
            shreg = {shreg[WIDTH-2:0], sdata}; nbits++; n_sclk++;
        end
        if (sclk === 1'b1 && p_sclk === 1'b1) begin
            checks++;
            if (sdata !== p_sdata) begin
                failures++; $display("FAIL sdata_stable t=%0t got=%b exp=%b", $time, sdata, p_sdata);
            end
        end
        if (sclk === 1'b1) hi_run++;
        else begin
            if (p_sclk && !rst) begin
                checks++;
                if (hi_run != CLK_DIV) begin
                    failures++; $display("FAIL sclk_high_len t=%0t got=%0d exp=%0d", $time, hi_run, CLK_DIV);
                end
            end
            hi_run = 0;
        end
        if (latch === 1'b1 && p_latch === 1'b0) begin
            n_latch++; cap_q.push_back(shreg);
            checks++;
            if (nbits != WIDTH) begin
                failures++; $display("FAIL bits_per_frame t=%0t got=%0d exp=%0d", $time, nbits, WIDTH);
            end
            checks++;
            if (shreg !== m_snap) begin
                failures++; $display("FAIL latched_word t=%0t got=%h exp=%h", $time, shreg, m_snap);
            end
            checks++;
            if (m_rem != CLK_DIV) begin
                failures++; $display("FAIL latch_timing t=%0t got_rem=%0d exp=%0d", $time, m_rem, CLK_DIV);
            end
            nbits = 0;
        end
        if (latch === 1'b1) lt_run++;
        else begin
            if (p_latch) begin
                latch_len = lt_run;
                checks++;
                if (lt_run != CLK_DIV) begin
                    failures++; $display("FAIL latch_len t=%0t got=%0d exp=%0d", $time, lt_run, CLK_DIV);
                end
            end
            lt_run = 0;
        end
        if (busy === 1'b1) bz_run++;
        else begin
            if (p_busy) busy_len = bz_run;
            bz_run = 0;
        end
        if (rst) nbits = 0;
        p_sclk = sclk; p_latch = latch; p_busy = busy; p_sdata = sdata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && m_rem == 0) quiet++; else quiet = 0;
            if (quiet >= 4) break;
        end
        checks++;
        if (quiet < 4) begin
            failures++; $display("FAIL %s_idle_timeout got=busy exp=idle", name);
        end
        tick(1);
    endtask

    task automatic wait_busy(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (busy) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL %s_busy_timeout got=0 exp=1", name);
        end
    endtask

    task automatic test_reset;
        int b;
        b = n_latch;
        rst = 1'b1; leds = '0;
        tick(2);
        checks++;
        if ({sdata, sclk, latch, busy, done} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=00000", {sdata, sclk, latch, busy, done});
        end
        rst = 1'b0;
        wait_idle("reset");
        checks++;
        if (n_latch - b != 1) begin
            failures++; $display("FAIL reset_frame_count got=%0d exp=1", n_latch - b);
        end
        checks++;
        if (cap_q.size() == 0 || cap_q[$] !== 16'h0000) begin
            failures++; $display("FAIL reset_frame_word got=%h exp=0000", cap_q.size() ? cap_q[$] : 'x);
        end
        checks++;
        if (busy_len != 132) begin
            failures++; $display("FAIL reset_busy_len got=%0d exp=132", busy_len);
        end
        b = n_busy_rise;
        tick(100);
        checks++;
        if (n_busy_rise != b) begin
            failures++; $display("FAIL reset_no_extra got=%0d exp=0", n_busy_rise - b);
        end
    endtask

    task automatic test_pattern;
        int b;
        b = n_latch;
        leds = 16'h8001;
        wait_idle("pattern");
        checks++;
        if (n_latch - b != 1 || cap_q[$] !== 16'h8001) begin
            failures++; $display("FAIL pattern_8001 got=%0d/%h exp=1/8001", n_latch - b, cap_q[$]);
        end
        checks++;
        if (latch_len != 4) begin
            failures++; $display("FAIL pattern_latch_len got=%0d exp=4", latch_len);
        end
    endtask

    task automatic test_hold;
        int bs, bb;
        leds = 16'hA5A5;
        wait_idle("hold");
        checks++;
        if (cap_q[$] !== 16'hA5A5) begin
            failures++; $display("FAIL hold_word got=%h exp=a5a5", cap_q[$]);
        end
        bs = n_sclk; bb = n_busy_rise;
        tick(1000);
        checks++;
        if (n_sclk != bs || n_busy_rise != bb) begin
            failures++; $display("FAIL hold_quiet got=%0d/%0d exp=0/0", n_sclk - bs, n_busy_rise - bb);
        end
    endtask

    task automatic test_change_mid_frame;
        int b;
        b = n_latch;
        leds = 16'h00FF;
        wait_busy("change");
        tick(20);
        leds = 16'hFF00;
        wait_idle("change");
        checks++;
        if (n_latch - b != 2) begin
            failures++; $display("FAIL change_frame_count got=%0d exp=2", n_latch - b);
        end
        checks++;
        if (cap_q.size() < 2 || cap_q[$-1] !== 16'h00FF || cap_q[$] !== 16'hFF00) begin
            failures++; $display("FAIL change_words got=%h,%h exp=00ff,ff00", cap_q[$-1], cap_q[$]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int b;
        b = n_latch;
        leds = 16'h1234;
        wait_busy("abort");
        tick(50);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({sdata, sclk, latch, busy, done} !== 5'b0) begin
            failures++; $display("FAIL abort_outputs got=%b exp=00000", {sdata, sclk, latch, busy, done});
        end
        checks++;
        if (n_latch != b) begin
            failures++; $display("FAIL abort_no_latch got=%0d exp=0", n_latch - b);
        end
        tick(1);
        rst = 1'b0;
        wait_idle("abort");
        checks++;
        if (n_latch - b != 1 || cap_q[$] !== 16'h1234) begin
            failures++; $display("FAIL abort_restart got=%0d/%h exp=1/1234", n_latch - b, cap_q[$]);
        end
    endtask

    task automatic test_refresh;
        int b;
        tick(5);
        b = n_latch;
        refresh = 1'b1; tick(1); refresh = 1'b0;
        wait_busy("refresh");
        tick(10);  refresh = 1'b1; tick(1); refresh = 1'b0;
        tick(30);  refresh = 1'b1; tick(1); refresh = 1'b0;
        tick(60);  refresh = 1'b1; tick(1); refresh = 1'b0;
        wait_idle("refresh");
        checks++;
        if (n_latch - b != 2 || cap_q[$] !== 16'h1234 || cap_q[$-1] !== 16'h1234) begin
            failures++; $display("FAIL refresh_extra got=%0d exp=2", n_latch - b);
        end
        b = n_latch;
        leds = 16'h4321; refresh = 1'b1; tick(1); refresh = 1'b0;
        wait_idle("refresh_coinc");
        checks++;
        if (n_latch - b != 1 || cap_q[$] !== 16'h4321) begin
            failures++; $display("FAIL refresh_coincident got=%0d/%h exp=1/4321", n_latch - b, cap_q[$]);
        end
    endtask

    task automatic test_random;
        int b, fm, r;
        b = n_latch; fm = m_frames;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if ((i / 500) % 2 == 1 && i % 500 < 40) leds = WIDTH'($urandom);
            else if (r < 2) leds = WIDTH'($urandom);
            refresh = (r >= 98);
            tick(1);
        end
        refresh = 1'b0;
        wait_idle("random");
        checks++;
        if (n_latch - b != m_frames - fm || n_latch == b) begin
            failures++; $display("FAIL random_frame_count got=%0d exp=%0d", n_latch - b, m_frames - fm);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pattern();
        test_hold();
        test_change_mid_frame();
        test_reset_mid_frame();
        test_refresh();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
